// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle; RISC-V DIVU/REMU on divide-by-zero.
// Latency WIDTH+1 cycles from accepted start to done (1 cycle for divide-by-zero); start ignored while busy.
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic             last_iter;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic             no_borrow;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] r_step;

    assign accept    = (state_q == S_IDLE) && start;
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // R_shifted can reach 2*D-1, so its top bit forces "no borrow" on its own;
    // the low bits go through a WIDTH+1-bit subtract whose carry-out is ~borrow.
    assign r_shift   = {r_q, q_q[WIDTH-1]};
    assign trial     = {1'b0, r_shift[WIDTH-1:0]} + {1'b0, ~d_q} + (WIDTH+1)'(1);
    assign no_borrow = r_shift[WIDTH] | trial[WIDTH];
    assign q_step    = {q_q[WIDTH-2:0], no_borrow};
    assign r_step    = no_borrow ? trial[WIDTH-1:0] : r_shift[WIDTH-1:0];

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (divisor == '0) ? S_DONE : S_RUN;
            S_RUN:   if (last_iter) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values; results are loaded on the edge into DONE and then held
    always_comb begin
        q_d    = q_q;
        r_d    = r_q;
        d_d    = d_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
        if (accept) begin
            q_d   = dividend;
            d_d   = divisor;
            r_d   = '0;
            cnt_d = '0;
            dbz_d = 1'b0;
            if (divisor == '0) begin
                quot_d = '1;
                rem_d  = dividend;
                dbz_d  = 1'b1;
            end
        end else if (state_q == S_RUN) begin
            q_d   = q_step;
            r_d   = r_step;
            cnt_d = cnt_q + CW'(1);
            if (last_iter) begin
                quot_d = q_step;
                rem_d  = r_step;
            end
        end
    end

    // Outputs
    always_comb begin
        busy        = (state_q == S_RUN) || (state_q == S_DONE);
        done        = (state_q == S_DONE);
        quotient    = quot_q;
        remainder   = rem_q;
        div_by_zero = dbz_q;
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and randomized checks of seq_restoring_divider (WIDTH=8) against hand-computed values.
module tb_seq_restoring_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int vectors    = 0;
    int miscompares = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE and advance to the done cycle.
    // cycles = edges from the accepting edge to done, or -1 if done never came.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int cycles);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        step();
        start  = 1'b0;
        cycles = 1;
        while (!done && cycles < 40) begin
            step();
            cycles++;
        end
        if (!done) cycles = -1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd0;
        step();
        step();
        vectors++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: busy/done/dbz=%b expected 000", {busy, done, div_by_zero});
        end
        vectors++;
        if (quotient !== 8'd0 || remainder !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_results: q=%0d r=%0d expected 0 0", quotient, remainder);
        end
        start = 1'b0;
        rst_n = 1'b1;
        step();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_basic();
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        step();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            vectors++;
            if (busy !== 1'b1 || done !== (c == 9)) begin
                miscompares++;
                $display("FAIL basic_timing cycle %0d: busy=%b done=%b expected busy=1 done=%b",
                         c, busy, done, (c == 9));
            end
            if (c < 9) step();
        end
        vectors++;
        if (quotient !== 8'd14 || remainder !== 8'd2 || div_by_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_100_7: q=%0d r=%0d dbz=%b expected 14 2 0", quotient, remainder, div_by_zero);
        end
        step();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 8'd14 || remainder !== 8'd2) begin
            miscompares++;
            $display("FAIL basic_hold: busy=%b done=%b q=%0d r=%0d expected 0 0 14 2",
                     busy, done, quotient, remainder);
        end
    endtask

    task automatic test_vectors();
        logic [W-1:0] va [4] = '{8'd255, 8'd255, 8'd3,  8'd128};
        logic [W-1:0] vb [4] = '{8'd1,   8'd255, 8'd10, 8'd200};
        logic [W-1:0] vq [4] = '{8'd255, 8'd1,   8'd0,  8'd0};
        logic [W-1:0] vr [4] = '{8'd0,   8'd0,   8'd3,  8'd128};
        int cyc;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], cyc);
            vectors++;
            if (cyc !== 9 || quotient !== vq[i] || remainder !== vr[i]) begin
                miscompares++;
                $display("FAIL vector %0d/%0d: cycles=%0d q=%0d r=%0d expected 9 %0d %0d",
                         va[i], vb[i], cyc, quotient, remainder, vq[i], vr[i]);
            end
            step();
        end
    endtask

    task automatic test_div_zero();
        int cyc;
        run_op(8'd5, 8'd0, cyc);
        vectors++;
        if (cyc !== 1 || quotient !== 8'hFF || remainder !== 8'd5 || div_by_zero !== 1'b1) begin
            miscompares++;
            $display("FAIL dbz_5_0: cycles=%0d q=%h r=%0d dbz=%b expected 1 ff 5 1",
                     cyc, quotient, remainder, div_by_zero);
        end
        step();
        vectors++;
        if (div_by_zero !== 1'b1 || quotient !== 8'hFF || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL dbz_hold: dbz=%b q=%h busy=%b expected 1 ff 0", div_by_zero, quotient, busy);
        end
        run_op(8'd9, 8'd3, cyc);
        vectors++;
        if (cyc !== 9 || quotient !== 8'd3 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL dbz_clear_9_3: cycles=%0d q=%0d r=%0d dbz=%b expected 9 3 0 0",
                     cyc, quotient, remainder, div_by_zero);
        end
        step();
    endtask

    task automatic test_start_ignored();
        int dones = 0;
        int busy_drop = 0;
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        step();
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 3) begin
                start    = 1'b1;
                dividend = 8'd50;
                divisor  = 8'd5;
            end else begin
                start = 1'b0;
            end
            if (c <= 9 && busy !== 1'b1) busy_drop++;
            if (done) dones++;
            if (c == 9) begin
                vectors++;
                if (done !== 1'b1 || quotient !== 8'd14 || remainder !== 8'd2) begin
                    miscompares++;
                    $display("FAIL ignore_result: done=%b q=%0d r=%0d expected 1 14 2", done, quotient, remainder);
                end
            end
            step();
        end
        vectors++;
        if (dones !== 1 || busy_drop !== 0) begin
            miscompares++;
            $display("FAIL ignore_pulses: done_pulses=%0d busy_drops=%0d expected 1 0", dones, busy_drop);
        end
    endtask

    task automatic test_reset_midrun();
        int dones = 0;
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 8'd0 || remainder !== 8'd0) begin
            miscompares++;
            $display("FAIL midrun_reset: busy=%b done=%b q=%0d r=%0d expected 0 0 0 0",
                     busy, done, quotient, remainder);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (done || busy) dones++;
            step();
        end
        vectors++;
        if (dones !== 0) begin
            miscompares++;
            $display("FAIL midrun_no_done: activity cycles=%0d expected 0", dones);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [W-1:0] a, b, eq, er;
        for (int i = 0; i < 1500; i++) begin
            a = W'($urandom_range(0, 255));
            b = (i % 50 == 7) ? 8'd0 : W'($urandom_range(0, 255));
            eq = (b == 0) ? 8'hFF : a / b;
            er = (b == 0) ? a : a % b;
            run_op(a, b, cyc);
            vectors++;
            if (cyc !== ((b == 0) ? 1 : 9) || quotient !== eq || remainder !== er ||
                div_by_zero !== (b == 0)) begin
                miscompares++;
                $display("FAIL sweep %0d/%0d: cycles=%0d q=%0d r=%0d dbz=%b expected q=%0d r=%0d dbz=%b",
                         a, b, cyc, quotient, remainder, div_by_zero, eq, er, (b == 0));
            end
            // start is reasserted in the cycle right after done
            step();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        test_reset();
        test_basic();
        test_vectors();
        test_div_zero();
        test_start_ignored();
        test_reset_midrun();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
